// File: rtl/jtag_master.sv
// jtag_master: host-side JTAG driver for the tck/tms/tdi/tdo link.
// Accepts TAP reset, IR shift, DR shift and idle commands on a valid/ready port,
// generates TCK from clk, walks the 1149.1 TAP state machine and returns the
// captured TDO bits on a valid/ready response port.
// Optional feature macro: JTAG_MASTER_TRST_EN (reset op pulses trstn_o before the TMS sequence).
module jtag_master #(
  parameter int CLK_DIV = 4,
  parameter int MAX_LEN = 64,
  localparam int LEN_W = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               tck_o,
  output logic               tms_o,
  output logic               tdi_o,
  input  logic               tdo_i,
  output logic               trstn_o
);

  // TCK index counter must hold the longest sequence: lead + 6 + MAX_LEN
  localparam int CNT_W = $clog2(MAX_LEN + 8);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  localparam logic [1:0] OP_RESET = 2'b00;
  localparam logic [1:0] OP_IR    = 2'b01;
  localparam logic [1:0] OP_DR    = 2'b10;
  localparam logic [1:0] OP_IDLE  = 2'b11;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_TRST,
    ST_SHIFT,
    ST_DONE
  } state_t;

`ifdef JTAG_MASTER_TRST_EN
  localparam int TRST_W = $clog2(2 * CLK_DIV + 1);
  localparam logic [TRST_W-1:0] TRST_MAX = TRST_W'(2 * CLK_DIV - 1);
  logic [TRST_W-1:0] trst_cnt;
  logic              trstn_r;
`endif

  state_t state, state_nxt;

  // Command captured on accept
  logic [1:0]         op_r;
  logic [LEN_W-1:0]   len_r;
  logic [MAX_LEN-1:0] data_r;
  logic               lead_r;
  logic [CNT_W-1:0]   tot_r;

  // TCK generation and sequence position
  logic [CNT_W-1:0]   tck_cnt;
  logic [DIV_W-1:0]   div_cnt;
  logic               tck_r;
  logic               tms_r;
  logic               tdi_r;
  logic [MAX_LEN-1:0] rsp_data_r;
  logic               in_tlr;

  // Decoded command and sequence lookups
  logic [LEN_W-1:0]   len_c;
  logic               lead_c;
  logic [CNT_W-1:0]   tot_c;
  logic               first_tms;
  logic               nxt_tms;
  logic               nxt_is_data;
  logic [LEN_W-1:0]   nxt_idx;
  logic               nxt_tdi;
  logic               cur_is_data;
  logic [LEN_W-1:0]   cur_idx;
  logic               shift_end;

  // TMS value of TCK number k. IR/DR: prefix (DR 1,0,x / IR 1,1,0,x) whose last
  // entry is 1 for a zero-length shift, then the data TCKs, then 1,0 back to RTI.
  function automatic logic seq_tms(input logic [CNT_W-1:0] k, input logic [1:0] op,
                                   input logic [LEN_W-1:0] len, input logic lead);
    logic [CNT_W-1:0] kk;
    logic [CNT_W-1:0] pre;
    logic [CNT_W-1:0] dend;
    logic             tms;
    kk   = k - CNT_W'(lead);
    pre  = (op == OP_IR) ? CNT_W'(4) : CNT_W'(3);
    dend = pre + CNT_W'(len);
    tms  = 1'b0;
    if (lead && (k == '0)) begin
      tms = 1'b0;
    end else begin
      case (op)
        OP_RESET: tms = (kk < CNT_W'(5));
        OP_IDLE:  tms = 1'b0;
        default: begin
          if (kk < pre) begin
            if (kk == pre - CNT_W'(1))   tms = (len == '0);
            else if (kk == '0)           tms = 1'b1;
            else                         tms = (op == OP_IR) && (kk == CNT_W'(1));
          end else if (kk < dend) begin
            tms = (kk == dend - CNT_W'(1));
          end else begin
            tms = (kk == dend);
          end
        end
      endcase
    end
    return tms;
  endfunction

  // Returns {is_data, bit index} for TCK number k
  function automatic logic [LEN_W:0] seq_slot(input logic [CNT_W-1:0] k, input logic [1:0] op,
                                              input logic [LEN_W-1:0] len, input logic lead);
    logic [CNT_W-1:0] kk;
    logic [CNT_W-1:0] pre;
    logic [LEN_W:0]   slot;
    kk   = k - CNT_W'(lead);
    pre  = (op == OP_IR) ? CNT_W'(4) : CNT_W'(3);
    slot = '0;
    if (((op == OP_IR) || (op == OP_DR)) && !(lead && (k == '0)) &&
        (kk >= pre) && (kk < pre + CNT_W'(len))) begin
      slot = {1'b1, LEN_W'(kk - pre)};
    end
    return slot;
  endfunction

  // Decode incoming command and look up current/next sequence entries
  always_comb begin
    len_c  = (cmd_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cmd_len;
    lead_c = in_tlr && (cmd_op != OP_RESET);
    case (cmd_op)
      OP_RESET: tot_c = CNT_W'(6);
      OP_IR:    tot_c = CNT_W'(6) + CNT_W'(len_c);
      OP_DR:    tot_c = CNT_W'(5) + CNT_W'(len_c);
      default:  tot_c = CNT_W'(len_c);
    endcase
    tot_c     = tot_c + CNT_W'(lead_c);
    first_tms = seq_tms('0, cmd_op, len_c, lead_c);
    nxt_tms   = seq_tms(tck_cnt + CNT_W'(1), op_r, len_r, lead_r);
    {nxt_is_data, nxt_idx} = seq_slot(tck_cnt + CNT_W'(1), op_r, len_r, lead_r);
    {cur_is_data, cur_idx} = seq_slot(tck_cnt, op_r, len_r, lead_r);
    nxt_tdi   = nxt_is_data && |(data_r & (MAX_LEN'(1) << nxt_idx));
    shift_end = (tck_cnt == tot_r) && !tck_r;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_INIT;
    else        state <= state_nxt;
  end

  // FSM next state and handshake outputs
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      ST_INIT: state_nxt = ST_IDLE;
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
`ifdef JTAG_MASTER_TRST_EN
          state_nxt = (cmd_op == OP_RESET) ? ST_TRST : ST_SHIFT;
`else
          state_nxt = ST_SHIFT;
`endif
        end
      end
`ifdef JTAG_MASTER_TRST_EN
      ST_TRST: if (trst_cnt == TRST_MAX) state_nxt = ST_SHIFT;
`endif
      ST_SHIFT: if (shift_end) state_nxt = ST_DONE;
      ST_DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  // Command capture, TCK divider, TMS/TDI on falling edges, TDO on rising edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r       <= OP_RESET;
      len_r      <= '0;
      data_r     <= '0;
      lead_r     <= 1'b0;
      tot_r      <= '0;
      tck_cnt    <= '0;
      div_cnt    <= '0;
      tck_r      <= 1'b0;
      tms_r      <= 1'b1;
      tdi_r      <= 1'b0;
      rsp_data_r <= '0;
      in_tlr     <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_r       <= cmd_op;
            len_r      <= len_c;
            data_r     <= cmd_data;
            lead_r     <= lead_c;
            tot_r      <= tot_c;
            tck_cnt    <= '0;
            div_cnt    <= '0;
            tck_r      <= 1'b0;
            tms_r      <= first_tms;
            tdi_r      <= 1'b0;
            rsp_data_r <= '0;
          end
        end
        ST_SHIFT: begin
          if (shift_end) begin
            in_tlr <= 1'b0;
          end else if (div_cnt == DIV_MAX) begin
            div_cnt <= '0;
            tck_r   <= ~tck_r;
            if (!tck_r) begin
              if (cur_is_data)
                rsp_data_r <= rsp_data_r | (MAX_LEN'(tdo_i) << cur_idx);
            end else begin
              tck_cnt <= tck_cnt + CNT_W'(1);
              tms_r   <= nxt_tms;
              tdi_r   <= nxt_tdi;
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef JTAG_MASTER_TRST_EN
  // TRST: held low after reset until the first clk, and for 2*CLK_DIV clk at the start of a reset op
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trstn_r  <= 1'b0;
      trst_cnt <= '0;
    end else begin
      case (state)
        ST_INIT: trstn_r <= 1'b1;
        ST_IDLE: begin
          if (cmd_valid && (cmd_op == OP_RESET)) begin
            trstn_r  <= 1'b0;
            trst_cnt <= '0;
          end
        end
        ST_TRST: begin
          if (trst_cnt == TRST_MAX) trstn_r  <= 1'b1;
          else                      trst_cnt <= trst_cnt + TRST_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign trstn_o = trstn_r;
`else
  assign trstn_o = 1'b1;
`endif

  assign tck_o    = tck_r;
  assign tms_o    = tms_r;
  assign tdi_o    = tdi_r;
  assign rsp_data = rsp_data_r;

endmodule
